// File: rtl/crc_block_gen_if.sv
// Handshake bundle between the CRC block generator and its producer/consumer.
// The producer drives data and clear; the checker side drives crc_ready.
interface crc_block_gen_if #(
    parameter int unsigned P_DATA_W = 16,
    parameter int unsigned P_CNT_W  = 16
);
    logic                i_clear;
    logic [P_DATA_W-1:0] i_data;
    logic                i_valid;
    logic                o_ready;
    logic [15:0]         o_crc;
    logic                o_crc_valid;
    logic                i_crc_ready;
    logic [P_CNT_W-1:0]  o_word_cnt;
    logic                o_busy;

    modport master (
        output i_clear, i_data, i_valid, i_crc_ready,
        input  o_ready, o_crc, o_crc_valid, o_word_cnt, o_busy
    );

    modport slave (
        input  i_clear, i_data, i_valid, i_crc_ready,
        output o_ready, o_crc, o_crc_valid, o_word_cnt, o_busy
    );
endinterface

// File: rtl/crc_block_gen.sv
// CRC-16-CCITT (poly 0x1021, MSB first, no final XOR) over fixed-length blocks,
// one word per clock, checksum handed off over a valid/ready handshake.
module crc_block_gen #(
    parameter int unsigned P_DATA_W    = 16,
    parameter int unsigned P_BLOCK_LEN = 256,
    parameter int unsigned P_CNT_W     = 16,
    parameter logic [15:0] P_CRC_INIT  = 16'hFFFF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    crc_block_gen_if.slave  bus
);

    localparam int unsigned    CRC_W = 16;
    localparam logic [CRC_W-1:0]   POLY  = 16'h1021;
    localparam logic [P_CNT_W-1:0] LAST  = P_CNT_W'(P_BLOCK_LEN - 1);

    typedef enum logic {S_ACCUM, S_OUTPUT} state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CRC_W-1:0]   crc_out_q, crc_out_d;
    logic               crc_vld_q, crc_vld_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_next;
    logic               ready_c;
    logic               accept_c;

    // Shift a whole word into the CRC register, MSB first.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                  input logic [P_DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = int'(P_DATA_W) - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    // Ready decodes registered state only; reset and clear force it low.
    assign ready_c  = (state_q == S_ACCUM) & ~bus.i_clear & i_rst_n;
    assign accept_c = bus.i_valid & ready_c;
    assign crc_next = crc_step(crc_q, bus.i_data);

    assign bus.o_ready     = ready_c;
    assign bus.o_crc       = crc_out_q;
    assign bus.o_crc_valid = crc_vld_q;
    assign bus.o_word_cnt  = cnt_q;
    assign bus.o_busy      = (state_q == S_OUTPUT) | (cnt_q != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_ACCUM;
            crc_q     <= P_CRC_INIT;
            crc_out_q <= '0;
            crc_vld_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            crc_vld_q <= crc_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state: clear wins, then accumulate or wait for the checksum handshake.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        crc_vld_d = crc_vld_q;
        cnt_d     = cnt_q;

        if (bus.i_clear) begin
            state_d   = S_ACCUM;
            crc_d     = P_CRC_INIT;
            crc_vld_d = 1'b0;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                S_ACCUM: begin
                    if (accept_c) begin
                        if (cnt_q == LAST) begin
                            crc_out_d = crc_next;
                            crc_vld_d = 1'b1;
                            crc_d     = P_CRC_INIT;
                            cnt_d     = '0;
                            state_d   = S_OUTPUT;
                        end else begin
                            crc_d = crc_next;
                            cnt_d = cnt_q + P_CNT_W'(1);
                        end
                    end
                end
                S_OUTPUT: begin
                    if (bus.i_crc_ready) begin
                        crc_vld_d = 1'b0;
                        state_d   = S_ACCUM;
                    end
                end
                default: state_d = S_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_block_gen.sv
// Directed bench: "123456789" on an 8-bit/9-word instance, counter stream on
// a default 16-bit/256-word instance against a byte-wise CRC reference.
module tb_crc_block_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc_block_gen_if #(.P_DATA_W(8),  .P_CNT_W(16)) a8 ();
    crc_block_gen_if #(.P_DATA_W(16), .P_CNT_W(16)) a16 ();

    crc_block_gen #(.P_DATA_W(8), .P_BLOCK_LEN(9), .P_CNT_W(16), .P_CRC_INIT(16'hFFFF)) dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (a8.slave)
    );

    crc_block_gen #(.P_DATA_W(16), .P_BLOCK_LEN(256), .P_CNT_W(16), .P_CRC_INIT(16'hFFFF)) dut16 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (a16.slave)
    );

    localparam logic [15:0] CHECK_CRC = 16'h29B1;

    int          total = 0;
    int          bad   = 0;
    int          w     = 0;
    int          blocks = 0;
    int          cyc   = 0;
    logic [15:0] mc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte-wise CCITT update; a 16-bit word is its high byte then its low byte.
    function automatic logic [15:0] ref_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] ref_word(input logic [15:0] c, input logic [15:0] d);
        return ref_byte(ref_byte(c, d[15:8]), d[7:0]);
    endfunction

    // Feed "123456789"; optional bubble after every word but the last.
    task automatic feed_str(input bit gaps);
        for (int i = 0; i < 9; i++) begin
            a8.i_data  = 8'(8'h31 + i);
            a8.i_valid = 1'b1;
            tick();
            check_eq("str_cnt", a8.o_word_cnt, (i < 8) ? 32'(i + 1) : 32'd0);
            if (gaps && i < 8) begin
                a8.i_valid = 1'b0;
                a8.i_data  = 'x;
                tick();
                check_eq("bubble_cnt", a8.o_word_cnt, 32'(i + 1));
                check_eq("bubble_vld", a8.o_crc_valid, 32'd0);
            end
        end
        a8.i_valid = 1'b0;
        a8.i_data  = 'x;
    endtask

    task automatic feed_four();
        for (int i = 0; i < 4; i++) begin
            a8.i_data  = 8'(8'h31 + i);
            a8.i_valid = 1'b1;
            tick();
        end
        a8.i_valid = 1'b0;
        check_eq("part_cnt", a8.o_word_cnt, 32'd4);
    endtask

    initial begin
        a8.i_clear = 1'b0;  a8.i_valid = 1'b0;  a8.i_data = '0;  a8.i_crc_ready = 1'b1;
        a16.i_clear = 1'b0; a16.i_valid = 1'b0; a16.i_data = '0; a16.i_crc_ready = 1'b1;

        // Reset values
        #1;
        check_eq("rst_ready", a8.o_ready, 32'd0);
        check_eq("rst_cnt",   a8.o_word_cnt, 32'd0);
        check_eq("rst_crc",   a8.o_crc, 32'd0);
        check_eq("rst_vld",   a8.o_crc_valid, 32'd0);
        check_eq("rst_busy",  a8.o_busy, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready", a8.o_ready, 32'd1);

        // Case 1: back-to-back check string
        feed_str(1'b0);
        check_eq("c1_vld",   a8.o_crc_valid, 32'd1);
        check_eq("c1_crc",   a8.o_crc, 32'(CHECK_CRC));
        check_eq("c1_ready", a8.o_ready, 32'd0);
        check_eq("c1_busy",  a8.o_busy, 32'd1);
        tick();
        check_eq("c1_vld_drop", a8.o_crc_valid, 32'd0);
        check_eq("c1_ready_back", a8.o_ready, 32'd1);
        check_eq("c1_busy_idle", a8.o_busy, 32'd0);

        // Case 3: backpressure for 5 cycles, with a word offered meanwhile
        a8.i_crc_ready = 1'b0;
        feed_str(1'b0);
        for (int k = 0; k < 5; k++) begin
            a8.i_valid = 1'b1;
            a8.i_data  = 8'hAA;
            #1;
            check_eq("bp_vld",   a8.o_crc_valid, 32'd1);
            check_eq("bp_crc",   a8.o_crc, 32'(CHECK_CRC));
            check_eq("bp_ready", a8.o_ready, 32'd0);
            tick();
        end
        a8.i_valid = 1'b0;
        check_eq("bp_hold_vld", a8.o_crc_valid, 32'd1);
        check_eq("bp_cnt", a8.o_word_cnt, 32'd0);
        a8.i_crc_ready = 1'b1;
        tick();
        check_eq("bp_hs_vld",   a8.o_crc_valid, 32'd0);
        check_eq("bp_hs_ready", a8.o_ready, 32'd1);
        check_eq("bp_hs_cnt",   a8.o_word_cnt, 32'd0);

        // Case 4: bubbles between words
        feed_str(1'b1);
        check_eq("bub_vld", a8.o_crc_valid, 32'd1);
        check_eq("bub_crc", a8.o_crc, 32'(CHECK_CRC));
        tick();

        // Case 5a: clear mid-block, word offered in the clear cycle is dropped
        feed_four();
        a8.i_clear = 1'b1;
        a8.i_valid = 1'b1;
        a8.i_data  = 8'h35;
        #1;
        check_eq("clr_ready", a8.o_ready, 32'd0);
        tick();
        a8.i_clear = 1'b0;
        a8.i_valid = 1'b0;
        check_eq("clr_cnt",  a8.o_word_cnt, 32'd0);
        check_eq("clr_vld",  a8.o_crc_valid, 32'd0);
        check_eq("clr_busy", a8.o_busy, 32'd0);
        feed_str(1'b0);
        check_eq("clr_next_vld", a8.o_crc_valid, 32'd1);
        check_eq("clr_next_crc", a8.o_crc, 32'(CHECK_CRC));
        tick();

        // Case 5b: clear during OUTPUT drops the pending checksum
        a8.i_crc_ready = 1'b0;
        feed_str(1'b0);
        check_eq("clro_vld_pre", a8.o_crc_valid, 32'd1);
        a8.i_clear = 1'b1;
        tick();
        a8.i_clear = 1'b0;
        #1;
        check_eq("clro_vld",   a8.o_crc_valid, 32'd0);
        check_eq("clro_ready", a8.o_ready, 32'd1);
        check_eq("clro_crc",   a8.o_crc, 32'(CHECK_CRC));
        a8.i_crc_ready = 1'b1;

        // Case 6: asynchronous reset mid-block, between clock edges
        feed_four();
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_cnt",   a8.o_word_cnt, 32'd0);
        check_eq("arst_ready", a8.o_ready, 32'd0);
        check_eq("arst_busy",  a8.o_busy, 32'd0);
        check_eq("arst_crc",   a8.o_crc, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check_eq("arst_rel_ready", a8.o_ready, 32'd1);
        feed_str(1'b0);
        check_eq("arst_next_crc", a8.o_crc, 32'(CHECK_CRC));
        check_eq("arst_next_vld", a8.o_crc_valid, 32'd1);
        tick();

        // Case 6b: reset while a checksum is pending; nothing reappears after release
        a8.i_crc_ready = 1'b0;
        feed_str(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arsto_vld", a8.o_crc_valid, 32'd0);
        check_eq("arsto_crc", a8.o_crc, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("arsto_rel_vld", a8.o_crc_valid, 32'd0);
        check_eq("arsto_rel_cnt", a8.o_word_cnt, 32'd0);
        a8.i_crc_ready = 1'b1;

        // Case 2: counter stream, 4 blocks of 256 words, default instance
        mc = 16'hFFFF;
        a16.i_valid = 1'b1;
        while (blocks < 4 && cyc < 1200) begin
            cyc++;
            if (a16.o_ready) begin
                a16.i_data = 16'(w);
                mc = ref_word(mc, 16'(w));
                w++;
                tick();
                if (w % 256 == 0) begin
                    check_eq("t2_vld",   a16.o_crc_valid, 32'd1);
                    check_eq("t2_crc",   a16.o_crc, 32'(mc));
                    check_eq("t2_ready", a16.o_ready, 32'd0);
                    check_eq("t2_wrap",  a16.o_word_cnt, 32'd0);
                    mc = 16'hFFFF;
                    blocks++;
                end else begin
                    check_eq("t2_mid_vld", a16.o_crc_valid, 32'd0);
                    check_eq("t2_cnt", a16.o_word_cnt, 32'(w % 256));
                end
            end else begin
                tick();
                check_eq("t2_gap", a16.o_ready, 32'd1);
            end
        end
        a16.i_valid = 1'b0;
        check_eq("t2_blocks", 32'(blocks), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
